message_normalize_buffer: RTL and testbench
===========================================

MESSAGE_NORMALIZE_BUFFER -- requirements
Module: message_normalize_buffer

Interface
REQ-001 The block SHALL have parameter LLR_Width, default 6, giving an LLR field of LLR_Width+1 bits, unsigned.
REQ-002 The block SHALL have parameter Q_Width, default 5, giving a symbol field of Q_Width+1 bits.
REQ-003 The block SHALL have parameter Counter_Width, default 4, giving the width of the entry/read counters.
REQ-004 The block SHALL have parameter N_M, default 8, giving the maximum stored list length; N_M SHALL be at most 2**Counter_Width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port force_reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an entry from the check-node output stage is present.
REQ-008 The block SHALL have port in_llr, input, LLR_Width+1 bits: the entry LLR; nondecreasing within a list.
REQ-009 The block SHALL have port in_q, input, Q_Width+1 bits: the entry symbol.
REQ-010 The block SHALL have port in_last, input, 1 bit: end of the current check-node output list.
REQ-011 The block SHALL have port in_ready, output, 1 bit: high while the block accepts entries.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_llr, out_q and out_last are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream variable-node stage accepts the entry.
REQ-014 The block SHALL have ports out_llr (output, LLR_Width+1 bits) and out_q (output, Q_Width+1 bits): the normalized entry.
REQ-015 The block SHALL have port out_last, output, 1 bit: the final entry of the emitted list.
REQ-016 The block SHALL have port order_err, output, 1 bit: sticky flag for an out-of-order input LLR.

Function
REQ-017 The block SHALL have two states: COLLECT and SEND.
REQ-018 In COLLECT, in_ready SHALL be 1 and out_valid SHALL be 0; in SEND, in_ready SHALL be 0.
REQ-019 An entry SHALL be accepted when in_valid=1 and in_ready=1.
REQ-020 An accepted entry SHALL be stored at index count, and count SHALL increment, only while count<N_M.
REQ-021 Entries accepted while count=N_M SHALL be dropped (truncation) with no other effect.
REQ-022 The LLR of the first stored entry of a list SHALL be held as the list minimum, min_llr.
REQ-023 Each stored LLR SHALL be held as in_llr-min_llr; if in_llr<min_llr, it SHALL be held as 0 and order_err SHALL be set.
REQ-024 in_last SHALL be sampled whenever in_ready=1; an entry carried in the same cycle SHALL be included in the list, subject to REQ-020.
REQ-025 On in_last with a resulting count>0, the state SHALL become SEND on the next edge, with out_valid=1 in the following cycle (1-cycle latency).
REQ-026 On in_last with a resulting count=0, the block SHALL remain in COLLECT and SHALL emit nothing.
REQ-027 In SEND, out_llr and out_q SHALL present entry rd_ptr, starting from rd_ptr=0.
REQ-028 rd_ptr SHALL advance only on out_valid=1 and out_ready=1; outputs SHALL be held stable while out_ready=0.
REQ-029 out_last SHALL be 1 exactly when rd_ptr=count-1.
REQ-030 On the final transfer, the state SHALL become COLLECT on the next edge, clearing count, rd_ptr and min_llr.
REQ-031 No input SHALL be accepted in the transfer cycle of the final entry.
REQ-032 order_err SHALL stay set until reset.

Reset
REQ-033 While force_reset=1 at a clock edge, the block SHALL set state=COLLECT, count=0, rd_ptr=0, min_llr=0 and order_err=0.
REQ-034 While force_reset=1 at a clock edge, the outputs SHALL become out_valid=0, out_last=0, out_llr=0, out_q=0 and in_ready=1.
REQ-035 Reset SHALL take precedence over all other events, including mid-SEND; a partially emitted list SHALL be discarded.

Verification
REQ-036 Scenario basic: send LLRs 3,5,9 with Q 7,2,4, in_last on the third entry, out_ready=1 -> output (0,7),(2,2),(6,4); out_last on (6,4); out_valid rises 1 cycle after in_last.
REQ-037 Scenario truncation: send 10 entries with LLRs 0..9 and N_M=8 -> exactly 8 entries out with LLRs 0..7 and out_last on the 8th.
REQ-038 Scenario backpressure: out_ready toggling 1,0,0,1 during SEND -> each entry held stable while stalled, no entry lost or duplicated, and in_ready=0 throughout SEND.
REQ-039 Scenario empty list: in_last alone with no entries -> out_valid stays 0 and in_ready stays 1.
REQ-040 Scenario order error: send LLRs 4 then 2 -> second entry output LLR 0 and order_err=1, remaining set after the list completes.
REQ-041 Scenario reset mid-SEND: assert force_reset after 1 of 3 entries is transferred -> next cycle out_valid=0, in_ready=1, and a new list of 1 entry (LLR 6, Q 1) outputs (0,1) with out_last=1.

Source files
------------

// File: rtl/message_normalize_buffer.sv
// message_normalize_buffer
//
// Collects one check-node output list (LLRs nondecreasing), subtracts the
// first stored LLR from every stored LLR, then replays the list to the
// variable-node stage.  Lists longer than N_M entries are truncated.
//
// Handshake: an input entry transfers on a rising edge where in_valid=1 and
// in_ready=1; an output entry transfers on a rising edge where out_valid=1
// and out_ready=1.  Payloads are held stable while valid is high and ready is
// low.  in_ready and out_valid are never high together.
//
// Ports:
//   clk, force_reset       clock, synchronous active-high reset
//   in_valid/in_ready      input handshake; in_llr, in_q, in_last payload
//   out_valid/out_ready    output handshake; out_llr, out_q, out_last payload
//   order_err              sticky: an input LLR was below the list minimum
//   dbg_state              current FSM state (0 = COLLECT, 1 = SEND)
module message_normalize_buffer #(
  parameter int LLR_Width     = 6,
  parameter int Q_Width       = 5,
  parameter int Counter_Width = 4,
  parameter int N_M           = 8
) (
  input  logic                 clk,
  input  logic                 force_reset,
  input  logic                 in_valid,
  input  logic [LLR_Width:0]   in_llr,
  input  logic [Q_Width:0]     in_q,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LLR_Width:0]   out_llr,
  output logic [Q_Width:0]     out_q,
  output logic                 out_last,
  output logic                 order_err,
  output logic [0:0]           dbg_state
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] SEND    = 1'b1;

  // Storage spans the whole read-pointer range so rd_ptr indexes it directly;
  // only the first N_M slots are ever written.
  localparam int DEPTH = 2 ** Counter_Width;
  // count must be able to hold N_M itself, hence one extra bit.
  localparam logic [Counter_Width:0] NM = (Counter_Width + 1)'(N_M);

  logic [0:0]               state;
  logic [Counter_Width:0]   count;
  logic [Counter_Width-1:0] rd_ptr;
  logic [LLR_Width:0]       min_llr;
  logic                     order_err_q;

  logic [LLR_Width:0] llr_mem [DEPTH];
  logic [Q_Width:0]   q_mem   [DEPTH];

  logic                   store;
  logic [Counter_Width:0] next_count;
  logic [LLR_Width:0]     norm_llr;
  logic                   norm_err;

  always_comb begin
    store      = (state == COLLECT) && in_valid && (count < NM);
    next_count = store ? count + 1'b1 : count;
    norm_llr   = '0;
    norm_err   = 1'b0;
    // The first stored entry defines the minimum, so it normalizes to 0.
    if (count != '0) begin
      if (in_llr < min_llr) begin
        norm_err = 1'b1;
      end else begin
        norm_llr = in_llr - min_llr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (force_reset) begin
      state       <= COLLECT;
      count       <= '0;
      rd_ptr      <= '0;
      min_llr     <= '0;
      order_err_q <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (store) begin
            count <= next_count;
            if (count == '0) begin
              min_llr <= in_llr;
            end
            if (norm_err) begin
              order_err_q <= 1'b1;
            end
          end
          // An empty list produces no output and leaves us collecting.
          if (in_last && (next_count != '0)) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state   <= COLLECT;
              count   <= '0;
              rd_ptr  <= '0;
              min_llr <= '0;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store && !force_reset) begin
      llr_mem[count[Counter_Width-1:0]] <= norm_llr;
      q_mem[count[Counter_Width-1:0]]   <= in_q;
    end
  end

  // Payload is forced to zero outside SEND so it reads 0 after reset even
  // though the storage itself is not cleared.
  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == SEND);
    out_llr   = out_valid ? llr_mem[rd_ptr] : '0;
    out_q     = out_valid ? q_mem[rd_ptr] : '0;
    out_last  = out_valid && ({1'b0, rd_ptr} == (count - 1'b1));
    order_err = order_err_q;
    dbg_state = state;
  end

endmodule

// File: tb/tb_message_normalize_buffer.sv
module tb_message_normalize_buffer;

  localparam int LW = 7;   // LLR_Width + 1
  localparam int QW = 6;   // Q_Width + 1
  localparam int NM = 8;
  localparam int EW = LW + QW + 1;

  logic          clk;
  logic          force_reset;
  logic          in_valid;
  logic [LW-1:0] in_llr;
  logic [QW-1:0] in_q;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_llr;
  logic [QW-1:0] out_q;
  logic          out_last;
  logic          order_err;
  logic [0:0]    dbg_state;

  message_normalize_buffer #(
    .LLR_Width(6), .Q_Width(5), .Counter_Width(4), .N_M(NM)
  ) dut (
    .clk(clk), .force_reset(force_reset),
    .in_valid(in_valid), .in_llr(in_llr), .in_q(in_q), .in_last(in_last),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_llr(out_llr), .out_q(out_q), .out_last(out_last),
    .order_err(order_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_xfer   = 0;
  logic          model_err = 1'b0;
  logic          started   = 1'b0;
  int            v_llr [16];
  int            v_q   [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- compare process ----------------
  logic          stall_prev = 1'b0;
  logic [EW-1:0] prev_out;

  always @(negedge clk) begin
    if (started && !force_reset) begin
      if (out_valid) begin
        check("in_ready_during_send", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          check("out_entry", {18'd0, out_llr, out_q, out_last}, {18'd0, exp_q[0]});
        end
        if (stall_prev) check("held_while_stalled", {18'd0, out_llr, out_q, out_last}, {18'd0, prev_out});
        stall_prev = !out_ready;
        prev_out   = {out_llr, out_q, out_last};
        if (out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          n_xfer++;
        end
      end else begin
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        stall_prev = 1'b0;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic v, input int llr, input int q, input logic last);
    in_valid = v;
    in_llr   = LW'(llr);
    in_q     = QW'(q);
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Builds the expected output list from v_llr/v_q, then drives it.
  task automatic send_list(input int n);
    int cnt;
    int mn;
    logic [EW-1:0] e;
    cnt = 0;
    mn  = 0;
    for (int i = 0; i < n; i++) begin
      if (cnt < NM) begin
        int val;
        if (cnt == 0) begin
          mn  = v_llr[i];
          val = 0;
        end else if (v_llr[i] < mn) begin
          val = 0;
          model_err = 1'b1;
        end else begin
          val = v_llr[i] - mn;
        end
        exp_q.push_back({LW'(val), QW'(v_q[i]), 1'b0});
        cnt++;
      end
    end
    if (cnt > 0) begin
      e = exp_q.pop_back();
      e[0] = 1'b1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      put(1'b1, v_llr[i], v_q[i], i == n - 1);
    end
    check("out_valid_latency", {31'd0, out_valid}, (cnt > 0) ? 32'd1 : 32'd0);
  endtask

  task automatic drain(input logic bp);
    logic [3:0] pat;
    logic done;
    pat  = 4'b1001;   // out_ready per cycle: 1,0,0,1
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      out_ready = bp ? pat[i % 4] : 1'b1;
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    out_ready = 1'b1;
    check("drain_done", {31'd0, done}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int x0;
    force_reset = 1'b1;
    in_valid = 1'b0; in_llr = '0; in_q = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_out_llr",   {25'd0, out_llr},   32'd0);
    check("rst_out_q",     {26'd0, out_q},     32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_order_err", {31'd0, order_err}, 32'd0);
    check("rst_state",     {31'd0, dbg_state}, 32'd0);
    force_reset = 1'b0;
    started = 1'b1;

    // basic: LLR 3,5,9 / Q 7,2,4 -> (0,7),(2,2),(6,4 last)
    v_llr[0] = 3; v_llr[1] = 5; v_llr[2] = 9;
    v_q[0]   = 7; v_q[1]   = 2; v_q[2]   = 4;
    x0 = n_xfer;
    fork
      send_list(3);
    join
    check("basic_model_size", exp_q.size(), 32'd3);
    check("basic_model_e0", {18'd0, exp_q[0]}, {18'd0, 7'd0, 6'd7, 1'b0});
    check("basic_model_e1", {18'd0, exp_q[1]}, {18'd0, 7'd2, 6'd2, 1'b0});
    check("basic_model_e2", {18'd0, exp_q[2]}, {18'd0, 7'd6, 6'd4, 1'b1});
    drain(1'b0);
    check("basic_count", n_xfer - x0, 32'd3);

    // truncation: LLR 0..9 -> 8 entries LLR 0..7, last on 8th
    for (int i = 0; i < 10; i++) begin
      v_llr[i] = i;
      v_q[i]   = 20 + i;
    end
    x0 = n_xfer;
    send_list(10);
    check("trunc_model_size", exp_q.size(), 32'd8);
    check("trunc_model_last", {18'd0, exp_q[7]}, {18'd0, 7'd7, 6'd27, 1'b1});
    drain(1'b0);
    check("trunc_count", n_xfer - x0, 32'd8);

    // backpressure: out_ready 1,0,0,1 during SEND
    v_llr[0] = 10; v_llr[1] = 11; v_llr[2] = 15; v_llr[3] = 40;
    v_q[0]   = 1;  v_q[1]   = 2;  v_q[2]   = 3;  v_q[3]   = 63;
    x0 = n_xfer;
    send_list(4);
    drain(1'b1);
    check("bp_count", n_xfer - x0, 32'd4);

    // empty list: in_last only
    x0 = n_xfer;
    put(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("empty_out_valid", {31'd0, out_valid}, 32'd0);
      check("empty_in_ready",  {31'd0, in_ready},  32'd1);
      @(posedge clk); #1;
    end
    check("empty_count", n_xfer - x0, 32'd0);

    // order error: LLR 4 then 2
    check("order_err_before", {31'd0, order_err}, 32'd0);
    v_llr[0] = 4; v_llr[1] = 2;
    v_q[0]   = 9; v_q[1]   = 8;
    send_list(2);
    check("order_model_e1", {18'd0, exp_q[1]}, {18'd0, 7'd0, 6'd8, 1'b1});
    check("order_err_set", {31'd0, order_err}, {31'd0, model_err});
    drain(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("order_err_sticky", {31'd0, order_err}, 32'd1);

    // reset mid-SEND after 1 of 3 entries
    v_llr[0] = 1; v_llr[1] = 2; v_llr[2] = 3;
    v_q[0]   = 1; v_q[1]   = 2; v_q[2]   = 3;
    x0 = n_xfer;
    send_list(3);
    @(posedge clk); #1;
    check("midsend_one_xfer", n_xfer - x0, 32'd1);
    force_reset = 1'b1;
    exp_q.delete();
    model_err = 1'b0;
    @(posedge clk); #1;
    force_reset = 1'b0;
    check("midsend_out_valid", {31'd0, out_valid}, 32'd0);
    check("midsend_in_ready",  {31'd0, in_ready},  32'd1);
    check("midsend_order_err", {31'd0, order_err}, 32'd0);
    v_llr[0] = 6; v_q[0] = 1;
    x0 = n_xfer;
    send_list(1);
    check("midsend_model_e0", {18'd0, exp_q[0]}, {18'd0, 7'd0, 6'd1, 1'b1});
    drain(1'b0);
    check("midsend_new_count", n_xfer - x0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
